sram_controller: RTL and testbench

Sequences the MEM-stage data-memory access onto a 16-bit asynchronous external SRAM. Each 32-bit load or store is split into two half-word SRAM cycles. The block drives `ready` low until the access completes, and the top level derives the pipeline freeze from it. It sits between `MEM_stage_module` (`mem_r_en`, `mem_w_en`, `alu_res`, `val_Rm`) and the SRAM pins.

---
 rtl/arm_mem_pkg.sv | 21 ++
 rtl/sram_wait_counter.sv | 27 ++
 rtl/sram_controller.sv | 149 ++++++++++++++
 tb/tb_sram_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types for the data-memory SRAM path: controller states, SRAM base address
// and the half-word select used to form the SRAM address LSB.
package arm_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_LO,
    W_HI,
    R_LO,
    R_HI,
    DONE
  } state_t;

  localparam int SRAM_BASE_ADDR = 1024;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase-length counter: restarts at 0 on every phase entry and flags the final
// cycle of a WAIT_CYCLES-long SRAM phase.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic last
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (!last)
      cnt <= cnt + CW'(1);
  end

  assign last = (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two half-word cycles on a 16-bit async SRAM.
// Optional macro SRAM_LAST_READ_HIT_EN adds a one-entry last-read buffer that short-circuits repeat loads.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  inout  tri   [15:0]       sram_dq,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int WORD_W = ADDR_W - 1;

  state_t            state, state_nxt;
  half_t             half;
  logic              last;
  logic              drive_dq;
  logic              hit;
  logic [WORD_W-1:0] word_in, word_q;
  logic [31:0]       wdata_q;

  assign word_in = WORD_W'((address - 32'(BASE_ADDR)) >> 2);

`ifdef SRAM_LAST_READ_HIT_EN
  logic              hit_vld;
  logic [WORD_W-1:0] hit_tag;
  logic [31:0]       hit_data;

  assign hit = hit_vld && (hit_tag == word_in);

  always_ff @(posedge clk) begin
    if (!rst)
      hit_vld <= 1'b0;
    else if (state == R_HI && last)
      hit_vld <= 1'b1;
  end

  // Write-through keeps the buffered copy coherent with the SRAM.
  always_ff @(posedge clk) begin
    if (state == R_HI && last) begin
      hit_tag  <= word_q;
      hit_data <= {sram_dq, read_data[15:0]};
    end else if (state == IDLE && wr_en && hit) begin
      hit_data <= write_data;
    end
  end
`else
  assign hit = 1'b0;
`endif

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_nxt != state),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // The final cycle of a write phase releases we_n while data is still driven (hold margin).
  always_comb begin
    state_nxt = state;
    half      = HALF_LO;
    drive_dq  = 1'b0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    case (state)
      IDLE: begin
        if (wr_en)
          state_nxt = W_LO;
        else if (rd_en)
          state_nxt = hit ? DONE : R_LO;
      end
      W_LO: begin
        drive_dq  = 1'b1;
        sram_we_n = last;
        if (last) state_nxt = W_HI;
      end
      W_HI: begin
        half      = HALF_HI;
        drive_dq  = 1'b1;
        sram_we_n = last;
        if (last) state_nxt = DONE;
      end
      R_LO: begin
        sram_oe_n = 1'b0;
        if (last) state_nxt = R_HI;
      end
      R_HI: begin
        half      = HALF_HI;
        sram_oe_n = 1'b0;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is captured every idle cycle, so it is frozen from the first phase cycle on.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      word_q  <= word_in;
      wdata_q <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      read_data <= '0;
`ifdef SRAM_LAST_READ_HIT_EN
    else if (state == IDLE && !wr_en && rd_en && hit)
      read_data <= hit_data;
`endif
    else if (state == R_LO && last)
      read_data[15:0] <= sram_dq;
    else if (state == R_HI && last)
      read_data[31:16] <= sram_dq;
  end

  assign sram_dq   = drive_dq ? ((half == HALF_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
  assign sram_addr = (state == IDLE) ? '0 : {word_q, logic'(half)};
  assign sram_ce_n = (state == IDLE);
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign ready     = ((state == IDLE) && !wr_en && !rd_en) || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed vector table, reset corner cases and a
// randomized load/store mix scored against a word-level memory model.
module tb_sram_controller;

  localparam int W = 2;
`ifdef SRAM_LAST_READ_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif
  localparam int LFULL = 2 * W + 2;
  localparam int LHIT  = HIT_EN ? 2 : LFULL;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  sram_controller #(
    .ADDR_W      (18),
    .WAIT_CYCLES (W),
    .BASE_ADDR   (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_dq    (sram_dq),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ce_n  (sram_ce_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SRAM: 64 half-words; tb_drive lets the bench probe for a released bus.
  logic [15:0] mem [0:63];
  logic        mem_clr;
  logic        tb_drive;

  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] :
                   (tb_drive ? 16'h0000 : 16'hzzzz);

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

  // Reference model: 16 CPU words plus the last-read tag rule.
  logic [31:0] ref_mem [0:15];
  bit          mdl_vld;
  int          mdl_tag;

  int checks;
  int failures;

  int          n_we, n_oe, n_ce;
  logic        rdy_c0;
  logic [17:0] we_addr [4];
  logic [15:0] we_dq   [4];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          drop_at;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic int word_idx(input logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) & 32'hF);
  endfunction

  // Called just after a rising edge; returns cycles from request to ready inclusive.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input int drop_at, output int lat, output logic [31:0] rdat);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    lat = -1; rdat = '0;
    n_we = 0; n_oe = 0; n_ce = 0; rdy_c0 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) rdy_c0 = ready;
      if (!sram_we_n) begin
        if (n_we < 4) begin
          we_addr[n_we] = sram_addr;
          we_dq[n_we]   = sram_dq;
        end
        n_we++;
      end
      if (!sram_oe_n) n_oe++;
      if (!sram_ce_n) n_ce++;
      if (ready) begin
        lat  = c + 1;
        rdat = read_data;
      end
      @(posedge clk);
      #1;
      if (c == drop_at) begin
        wr_en = 1'b0; rd_en = 1'b0;
        address = $urandom; write_data = $urandom;
      end
      if (lat >= 0) break;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic apply(input string nm, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input int drop_at, input int exp_lat,
                       input logic [31:0] exp_rd);
    int          lat;
    logic [31:0] rdat;
    int          k;
    access(wr, rd, a, d, drop_at, lat, rdat);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    if (wr) begin
      chk({nm, " oe_n cycles"}, 32'(n_oe), 32'd0);
      chk({nm, " we_n cycles"}, 32'(n_we), 32'(2 * (W - 1)));
    end else begin
      chk({nm, " read_data"}, rdat, exp_rd);
      chk({nm, " we_n cycles"}, 32'(n_we), 32'd0);
      if (exp_lat == 2) chk({nm, " hit oe_n cycles"}, 32'(n_oe), 32'd0);
    end
    k = word_idx(a);
    if (wr) ref_mem[k] = d;
    else begin
      mdl_vld = 1'b1;
      mdl_tag = k;
    end
  endtask

  task automatic do_txn(input string nm, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input int drop_at);
    int k;
    int elat;
    k = word_idx(a);
    elat = (!wr && HIT_EN && mdl_vld && mdl_tag == k) ? 2 : LFULL;
    apply(nm, wr, rd, a, d, drop_at, elat, ref_mem[k]);
  endtask

  initial begin
    checks = 0; failures = 0;
    mdl_vld = 1'b0; mdl_tag = 0;
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'h0;

    // Reset held with a pending load.
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b1; address = 32'd1028; write_data = 32'hFFFF_FFFF;
    tb_drive = 1'b1; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset we_n", 32'(sram_we_n), 32'd1);
    chk("reset oe_n", 32'(sram_oe_n), 32'd1);
    chk("reset ce_n", 32'(sram_ce_n), 32'd1);
    chk("reset read_data", read_data, 32'h0);
    chk("reset dq released", 32'(sram_dq), 32'h0);
    chk("reset sram_addr", 32'(sram_addr), 32'h0);
    chk("reset ready with rd_en", 32'(ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; tb_drive = 1'b0; mem_clr = 1'b0;
    apply("post-reset load", 1'b0, 1'b1, 32'd1028, 32'h0, -1, LFULL, 32'h0);
    chk("post-reset ready cycle0", 32'(rdy_c0), 32'd0);

    // Store with pin-level checks.
    apply("store 1028", 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, -1, LFULL, 32'h0);
    chk("store lo addr", 32'(we_addr[0]), 32'd2);
    chk("store lo dq", 32'(we_dq[0]), 32'h0000_BEEF);
    chk("store hi addr", 32'(we_addr[1]), 32'd3);
    chk("store hi dq", 32'(we_dq[1]), 32'h0000_DEAD);
    apply("load 1028", 1'b0, 1'b1, 32'd1028, 32'h0, -1, LHIT, 32'hDEAD_BEEF);

    tv[0] = '{1'b1, 1'b0, 32'd1028, 32'h1234_5678, -1, LFULL, 32'h0};
    tv[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,         -1, LHIT,  32'h1234_5678};
    tv[2] = '{1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A, -1, LFULL, 32'h0};
    tv[3] = '{1'b0, 1'b1, 32'd1032, 32'h0,         -1, LFULL, 32'hA5A5_5A5A};
    tv[4] = '{1'b0, 1'b1, 32'd1035, 32'h0,         -1, LHIT,  32'hA5A5_5A5A};
    tv[5] = '{1'b0, 1'b1, 32'd1024, 32'h0,          2, LFULL, 32'h0};
    tv[6] = '{1'b1, 1'b0, 32'd1040, 32'hCAFE_F00D,  1, LFULL, 32'h0};
    tv[7] = '{1'b0, 1'b1, 32'd1040, 32'h0,         -1, LFULL, 32'hCAFE_F00D};
    tv[8] = '{1'b0, 1'b1, 32'd1041, 32'h0,          0, LHIT,  32'hCAFE_F00D};
    for (int i = 0; i < 9; i++)
      apply($sformatf("vec%0d", i), tv[i].wr, tv[i].rd, tv[i].addr, tv[i].wdata,
            tv[i].drop_at, tv[i].exp_lat, tv[i].exp_rd);

    @(negedge clk);
    chk("idle ready", 32'(ready), 32'd1);
    @(posedge clk); #1;

    // Reset pulsed in W_HI of a store to 1044.
    wr_en = 1'b1; address = 32'd1044; write_data = 32'h8765_4321;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("whi sram_addr", 32'(sram_addr), 32'd11);
    chk("whi dq", 32'(sram_dq), 32'h0000_8765);
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    tb_drive = 1'b1;
    @(negedge clk);
    chk("abort we_n", 32'(sram_we_n), 32'd1);
    chk("abort ce_n", 32'(sram_ce_n), 32'd1);
    chk("abort oe_n", 32'(sram_oe_n), 32'd1);
    chk("abort dq released", 32'(sram_dq), 32'h0);
    chk("abort read_data", read_data, 32'h0);
    chk("abort ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; tb_drive = 1'b0; mdl_vld = 1'b0;
    do_txn("load after abort", 1'b0, 1'b1, 32'd1040, 32'h0, -1);
    do_txn("rewrite 1044", 1'b1, 1'b0, 32'd1044, 32'h0BAD_CAFE, -1);

    // Randomized mix against the model.
    for (int i = 0; i < 150; i++) begin
      int          k;
      int          op;
      int          dr;
      logic [31:0] a;
      k  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) k = mdl_tag;
      op = $urandom_range(0, 3);
      dr = $urandom_range(0, 8);
      a  = 32'd1024 + 32'(4 * k) + 32'($urandom_range(0, 3));
      do_txn("rand", (op >= 2), (op != 2), a, $urandom, (dr > 6) ? -1 : dr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
